// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Groups the operation handshake and result bus of serial_subtractor.
//   Parameter WIDTH : operand/result width in bits.
//   Requester side (master) drives: start, a, b
//   Subtractor side (slave) drives: busy, done, diff, borrow, zero
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = (a - b) mod 2^WIDTH,
//   one bit per clock, LSB first, through a single full-subtractor cell
//   with a registered borrow.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : serial_subtractor_if.slave
//             start/a/b in; busy, done (1-cycle pulse), diff, borrow
//             (unsigned a < b) and zero (diff == 0) out, all registered.
//   Results change only when a run completes (or on reset) and are held
//   across IDLE and across the following run.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(
        input logic a0,
        input logic b0,
        input logic bin
    );
        logic d;
        logic bout;
        d    = a0 ^ b0 ^ bin;
        bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
        return {bout, d};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sd_r;
    logic             bw_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             zero_r;

    logic             d_s;
    logic             bw_next_s;
    logic [WIDTH-1:0] sd_next_s;
    logic             last_s;

    // Current bit slice: difference bit, next borrow, shifted result, last-bit flag.
    always_comb begin
        {bw_next_s, d_s} = full_sub(sa_r[0], sb_r[0], bw_r);
        sd_next_s        = {d_s, sd_r[WIDTH-1:1]};
        last_s           = (count_r == CW'(WIDTH - 1));
    end

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            sd_r     <= {WIDTH{1'b0}};
            bw_r     <= 1'b0;
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sa_r    <= bus.a;
                        sb_r    <= bus.b;
                        sd_r    <= {WIDTH{1'b0}};
                        bw_r    <= 1'b0;
                        count_r <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
                    sd_r    <= sd_next_s;
                    bw_r    <= bw_next_s;
                    count_r <= count_r + CW'(32'd1);
                    if (last_s) begin
                        // Publish from the post-shift value so the MSB bit
                        // computed on this edge is included.
                        diff_r   <= sd_next_s;
                        borrow_r <= bw_next_s;
                        zero_r   <= (sd_next_s == {WIDTH{1'b0}});
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_r;
    assign bus.zero   = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor with a WIDTH=8 and a
//   WIDTH=2 instance sharing one clock and reset. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] held_diff;
    logic       held_borrow;
    logic       held_zero;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(2)) bus2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] op_a(input int c);
        return 8'(c * 29 + 7);
    endfunction

    function automatic logic [7:0] op_b(input int c);
        return 8'(c * 53 + 100);
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = 8'h00;
        bus8.b     = 8'h00;
        bus2.start = 1'b0;
        bus2.a     = 2'd0;
        bus2.b     = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow, bus8.zero} !== 12'h000) begin
            $display("FAIL reset8: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.borrow, bus8.zero);
            n_err++;
        end
        n_vec++;
        if ({bus2.busy, bus2.done, bus2.diff, bus2.borrow, bus2.zero} !== 6'h00) begin
            $display("FAIL reset2: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
                     bus2.busy, bus2.done, bus2.diff, bus2.borrow, bus2.zero);
            n_err++;
        end
        held_diff   = 8'h00;
        held_borrow = 1'b0;
        held_zero   = 1'b0;
    endtask

    // One WIDTH=8 operation with hand-computed expectations; checks busy
    // for 8 cycles with old results held, the done pulse, and its end.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] e_diff, input logic e_borrow,
                           input logic e_zero, input string name);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            n_vec++;
            if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
                $display("FAIL %s busy cycle %0d: got busy=%b done=%b want busy=1 done=0",
                         name, i, bus8.busy, bus8.done);
                n_err++;
            end
            n_vec++;
            if (bus8.diff !== held_diff || bus8.borrow !== held_borrow || bus8.zero !== held_zero) begin
                $display("FAIL %s hold cycle %0d: got diff=%h borrow=%b zero=%b want %h %b %b",
                         name, i, bus8.diff, bus8.borrow, bus8.zero, held_diff, held_borrow, held_zero);
                n_err++;
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
            $display("FAIL %s done: got done=%b busy=%b want done=1 busy=0", name, bus8.done, bus8.busy);
            n_err++;
        end
        n_vec++;
        if (bus8.diff !== e_diff || bus8.borrow !== e_borrow || bus8.zero !== e_zero) begin
            $display("FAIL %s result: got diff=%h borrow=%b zero=%b want %h %b %b",
                     name, bus8.diff, bus8.borrow, bus8.zero, e_diff, e_borrow, e_zero);
            n_err++;
        end
        held_diff   = e_diff;
        held_borrow = e_borrow;
        held_zero   = e_zero;
        @(negedge clk);
        n_vec++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            $display("FAIL %s after done: got done=%b busy=%b want 0 0", name, bus8.done, bus8.busy);
            n_err++;
        end
    endtask

    task automatic test_basic();
        run_op8(8'd200, 8'd55, 8'h91, 1'b0, 1'b0, "basic_200_55");
    endtask

    task automatic test_borrow_hold();
        run_op8(8'd55, 8'd200, 8'h6F, 1'b1, 1'b0, "borrow_55_200");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus8.done !== 1'b0 || bus8.diff !== 8'h6F || bus8.borrow !== 1'b1 || bus8.zero !== 1'b0) begin
                $display("FAIL hold_idle cycle %0d: got done=%b diff=%h borrow=%b zero=%b want 0 6f 1 0",
                         i, bus8.done, bus8.diff, bus8.borrow, bus8.zero);
                n_err++;
            end
        end
    endtask

    task automatic test_zero_wrap();
        run_op8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, "zero_5a_5a");
        run_op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "wrap_00_01");
    endtask

    // start held high with fresh operands every cycle: accepts land every
    // 10 cycles (8 RUN, 1 DONE, 1 IDLE); operands presented elsewhere are ignored.
    task automatic test_back_to_back();
        logic [7:0] e_diff;
        logic       exp_done;
        logic       exp_busy;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c > 0) begin
                exp_done = (c % 10 == 9);
                exp_busy = (c % 10 >= 1) && (c % 10 <= 8);
                n_vec++;
                if (bus8.done !== exp_done || bus8.busy !== exp_busy) begin
                    $display("FAIL b2b cycle %0d: got done=%b busy=%b want done=%b busy=%b",
                             c, bus8.done, bus8.busy, exp_done, exp_busy);
                    n_err++;
                end
                if (exp_done) begin
                    e_diff      = op_a(c - 9) - op_b(c - 9);
                    held_diff   = e_diff;
                    held_borrow = (op_a(c - 9) < op_b(c - 9));
                    held_zero   = (e_diff == 8'h00);
                end
                n_vec++;
                if (bus8.diff !== held_diff || bus8.borrow !== held_borrow || bus8.zero !== held_zero) begin
                    $display("FAIL b2b result cycle %0d: got diff=%h borrow=%b zero=%b want %h %b %b",
                             c, bus8.diff, bus8.borrow, bus8.zero, held_diff, held_borrow, held_zero);
                    n_err++;
                end
            end
            if (c < 30) begin
                bus8.start = 1'b1;
                bus8.a     = op_a(c);
                bus8.b     = op_b(c);
            end else begin
                bus8.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow, bus8.zero} !== 12'h000) begin
            $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.borrow, bus8.zero);
            n_err++;
        end
        @(negedge clk);
        rst_n       = 1'b1;
        held_diff   = 8'h00;
        held_borrow = 1'b0;
        held_zero   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
                $display("FAIL aborted_op cycle %0d: got done=%b busy=%b want 0 0", i, bus8.done, bus8.busy);
                n_err++;
            end
        end
        run_op8(8'd9, 8'd4, 8'h05, 1'b0, 1'b0, "after_reset_9_4");
    endtask

    task automatic test_width2();
        logic [1:0] e_diff;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                bus2.start = 1'b1;
                bus2.a     = 2'(a);
                bus2.b     = 2'(b);
                @(negedge clk);
                bus2.start = 1'b0;
                n_vec++;
                if (bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
                    $display("FAIL w2 a=%0d b=%0d cycle1: got busy=%b done=%b want 1 0", a, b, bus2.busy, bus2.done);
                    n_err++;
                end
                @(negedge clk);
                n_vec++;
                if (bus2.busy !== 1'b1 || bus2.done !== 1'b0) begin
                    $display("FAIL w2 a=%0d b=%0d cycle2: got busy=%b done=%b want 1 0", a, b, bus2.busy, bus2.done);
                    n_err++;
                end
                @(negedge clk);
                e_diff = 2'(a - b);
                n_vec++;
                if (bus2.done !== 1'b1 || bus2.diff !== e_diff || bus2.borrow !== (a < b) ||
                    bus2.zero !== (a == b)) begin
                    $display("FAIL w2 a=%0d b=%0d: got done=%b diff=%0d borrow=%b zero=%b want 1 %0d %b %b",
                             a, b, bus2.done, bus2.diff, bus2.borrow, bus2.zero, e_diff, (a < b), (a == b));
                    n_err++;
                end
                @(negedge clk);
                n_vec++;
                if (bus2.done !== 1'b0 || bus2.busy !== 1'b0) begin
                    $display("FAIL w2 a=%0d b=%0d idle: got done=%b busy=%b want 0 0", a, b, bus2.done, bus2.busy);
                    n_err++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_hold();
        test_zero_wrap();
        test_back_to_back();
        test_reset_mid_op();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
